keccak_sched: RTL and testbench

KECCAK_SCHED -- requirements
Module: keccak_sched

---
 rtl/sha_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/keccak_sched.sv | 128 ++++++++++++
 tb/tb_keccak_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the keccak_xor core scheduler.
package sha_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_RESULT
  } sched_state_t;

  // Default core-completion timeout in cycles
  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             hit,
  output logic [IW-1:0]    idx
);

  // Scan from ptr upward, wrapping at N_REQ; the first hit wins
  always_comb begin
    int unsigned j;
    logic [IW-1:0] jx;
    hit = 1'b0;
    idx = '0;
    j   = 0;
    jx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = ptr + i;
      if (j >= N_REQ) j = j - N_REQ;
      jx = IW'(j);
      if (!hit && req[jx]) begin
        hit = 1'b1;
        idx = jx;
      end
    end
  end

endmodule

// File: rtl/keccak_sched.sv
// Arbitrates N_REQ message requesters onto one keccak_xor permutation core,
// locking the core to one owner for a whole multi-block message.
module keccak_sched
  import sha_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_last,
  output logic [N_REQ-1:0] blk_ack,
  output logic [N_REQ-1:0] grant,
  output logic             core_valid,
  output logic             core_last,
  input  logic             core_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_id,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

  sched_state_t  state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic          last_q;
  logic [15:0]   cnt;

  logic          pick_hit;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_after;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign ptr_after = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Scheduler FSM; all outputs registered. Strobes for ISSUE are loaded on
  // the edge entering ISSUE so they are visible for exactly that cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      grant       <= '0;
      blk_ack     <= '0;
      core_valid  <= 1'b0;
      core_last   <= 1'b0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      blk_ack    <= '0;
      core_valid <= 1'b0;
      core_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_hit) begin
            owner      <= pick_idx;
            grant      <= ONE << pick_idx;
            blk_ack    <= ONE << pick_idx;
            core_valid <= 1'b1;
            core_last  <= req_last[pick_idx];
            last_q     <= req_last[pick_idx];
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            if (last_q) begin
              res_valid <= 1'b1;
              res_id    <= owner;
              state     <= S_RESULT;
            end else begin
              state <= S_NEXT;
            end
          end else if (cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            busy        <= 1'b0;
            rr_ptr      <= ptr_after;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_NEXT: begin
          if (req_valid[owner]) begin
            blk_ack    <= ONE << owner;
            core_valid <= 1'b1;
            core_last  <= req_last[owner];
            last_q     <= req_last[owner];
            state      <= S_ISSUE;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            rr_ptr    <= ptr_after;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_sched.sv
// Directed self-checking bench for keccak_sched.
module tb_keccak_sched;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;

  // main instance (default TIMEOUT)
  logic [1:0] req_valid = '0, req_last = '0;
  logic [1:0] blk_ack, grant;
  logic       core_valid, core_last, core_ready = 1'b0;
  logic       res_valid, res_ready = 1'b0, busy, timeout_err;
  logic [0:0] res_id;

  // short-timeout instance
  logic [1:0] t_req_valid = '0, t_req_last = '0;
  logic [1:0] t_blk_ack, t_grant;
  logic       t_core_valid, t_core_last, t_core_ready = 1'b0;
  logic       t_res_valid, t_res_ready = 1'b0, t_busy, t_timeout_err;
  logic [0:0] t_res_id;

  int tests = 0;
  int fails = 0;

  keccak_sched #(.N_REQ(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req_valid(req_valid), .req_last(req_last),
    .blk_ack(blk_ack), .grant(grant), .core_valid(core_valid), .core_last(core_last),
    .core_ready(core_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .busy(busy), .timeout_err(timeout_err)
  );

  keccak_sched #(.N_REQ(2), .TIMEOUT(8)) dut_t (
    .ACLK(ACLK), .ARESETn(ARESETn), .req_valid(t_req_valid), .req_last(t_req_last),
    .blk_ack(t_blk_ack), .grant(t_grant), .core_valid(t_core_valid), .core_last(t_core_last),
    .core_ready(t_core_ready), .res_valid(t_res_valid), .res_ready(t_res_ready),
    .res_id(t_res_id), .busy(t_busy), .timeout_err(t_timeout_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; req_last = '0; core_ready = 0; res_ready = 0;
    t_req_valid = '0; t_req_last = '0; t_core_ready = 0; t_res_ready = 0;
    ARESETn = 0;
    tick(); tick();
    ARESETn = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({grant, blk_ack, core_valid, core_last, res_valid, res_id, busy, timeout_err} !== 10'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 0", {grant, blk_ack, core_valid, core_last, res_valid, res_id, busy, timeout_err}); end
    tests++; if ({t_grant, t_core_valid, t_busy, t_timeout_err} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs_t: got %b want 0", {t_grant, t_core_valid, t_busy, t_timeout_err}); end
  endtask

  // single-block message on req 0, core_ready 24 cycles after core_valid
  task automatic test_single_block();
    int pulses;
    do_reset();
    req_valid = 2'b01; req_last = 2'b01;
    tick();
    tests++; if ({grant, core_valid, core_last, blk_ack, busy} !== 7'b01_1_1_01_1) begin
      fails++; $display("FAIL single_issue: got %b want 0111011", {grant, core_valid, core_last, blk_ack, busy}); end
    req_valid = 2'b00; req_last = 2'b00;
    pulses = 0;
    for (int i = 0; i < 23; i++) begin tick(); if (core_valid) pulses++; end
    core_ready = 1;
    tick();
    core_ready = 0;
    tests++; if (pulses !== 0) begin fails++; $display("FAIL single_extra_core_valid: got %0d want 0", pulses); end
    tests++; if ({res_valid, res_id, grant, busy} !== 5'b1_0_01_1) begin
      fails++; $display("FAIL single_result: got %b want 10011", {res_valid, res_id, grant, busy}); end
    res_ready = 1;
    tick();
    res_ready = 0;
    tests++; if ({res_valid, grant, busy} !== 4'b0) begin
      fails++; $display("FAIL single_done: got %b want 0000", {res_valid, grant, busy}); end
    // res_ready with no result pending must not disturb anything
    res_ready = 1;
    tick(); tick();
    res_ready = 0;
    tests++; if ({res_valid, grant, busy} !== 4'b0) begin
      fails++; $display("FAIL stray_res_ready: got %b want 0000", {res_valid, grant, busy}); end
  endtask

  // both requesters continuously valid: 0, then 1, then 0 again
  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset();
    req_valid = 2'b11; req_last = 2'b11;
    for (int r = 0; r < 3; r++) begin
      tick();
      tests++; if ({grant, core_valid, blk_ack} !== {exp_g[r], 1'b1, exp_g[r]}) begin
        fails++; $display("FAIL rr_grant_%0d: got %b want %b", r, {grant, core_valid, blk_ack}, {exp_g[r], 1'b1, exp_g[r]}); end
      core_ready = 1;          // ISSUE cycle: must be ignored
      tick();
      core_ready = 0;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rr_ready_in_issue_%0d: got %b want 0", r, res_valid); end
      core_ready = 1;
      tick();
      core_ready = 0;
      tests++; if ({res_valid, res_id} !== {1'b1, exp_g[r][1]}) begin
        fails++; $display("FAIL rr_result_%0d: got %b want %b", r, {res_valid, res_id}, {1'b1, exp_g[r][1]}); end
      res_ready = 1;
      tick();
      res_ready = 0;
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rr_release_%0d: got %b want 00", r, grant); end
    end
    req_valid = '0; req_last = '0;
  endtask

  // 3-block message on req 1 while req 0 stays valid
  task automatic test_multiblock();
    int pulses;
    do_reset();
    req_valid = 2'b10; req_last = 2'b00;
    tick();
    req_valid = 2'b11;
    pulses = 0;
    tests++; if ({grant, core_valid, core_last} !== 4'b10_1_0) begin
      fails++; $display("FAIL mb_issue_0: got %b want 1010", {grant, core_valid, core_last}); end
    if (core_valid) pulses++;
    for (int b = 1; b < 3; b++) begin
      tick();
      core_ready = 1;
      tick();
      core_ready = 0;
      req_last = (b == 2) ? 2'b10 : 2'b00;
      tick();
      tests++; if ({grant, core_valid, core_last, blk_ack} !== {2'b10, 1'b1, (b == 2), 2'b10}) begin
        fails++; $display("FAIL mb_issue_%0d: got %b want %b", b, {grant, core_valid, core_last, blk_ack}, {2'b10, 1'b1, (b == 2), 2'b10}); end
      if (core_valid) pulses++;
    end
    tick();
    core_ready = 1;
    tick();
    core_ready = 0;
    tests++; if ({res_valid, res_id, grant} !== 4'b1_1_10) begin
      fails++; $display("FAIL mb_result: got %b want 1110", {res_valid, res_id, grant}); end
    tests++; if (pulses !== 3) begin fails++; $display("FAIL mb_pulse_count: got %0d want 3", pulses); end
    tick(); tick();
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL mb_lock: got %b want 10", grant); end
    req_valid = 2'b01; req_last = 2'b01;
    res_ready = 1;
    tick();
    res_ready = 0;
    tick();
    tests++; if ({grant, core_valid} !== 3'b01_1) begin
      fails++; $display("FAIL mb_next_owner: got %b want 011", {grant, core_valid}); end
    req_valid = '0; req_last = '0;
  endtask

  // RESULT held 20 cycles with a stray core_ready and a competing request
  task automatic test_result_hold();
    int bad;
    do_reset();
    req_valid = 2'b01; req_last = 2'b01;
    tick();
    req_valid = 2'b10; req_last = 2'b10;
    tick();
    core_ready = 1;
    tick();
    core_ready = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      core_ready = (i == 7);
      if ({res_valid, res_id, grant, core_valid, blk_ack} !== 7'b1_0_01_0_00) bad++;
      tick();
    end
    core_ready = 0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    res_ready = 1;
    tick();
    res_ready = 0;
    tick();
    tests++; if ({grant, res_valid} !== 3'b10_0) begin
      fails++; $display("FAIL hold_then_next: got %b want 100", {grant, res_valid}); end
    req_valid = '0; req_last = '0;
  endtask

  // TIMEOUT=8 instance: abort, then a normal message on req 1
  task automatic test_timeout();
    do_reset();
    t_req_valid = 2'b01; t_req_last = 2'b01;
    tick();
    t_req_valid = '0; t_req_last = '0;
    tests++; if ({t_grant, t_core_valid} !== 3'b01_1) begin
      fails++; $display("FAIL to_issue: got %b want 011", {t_grant, t_core_valid}); end
    for (int i = 0; i < 8; i++) tick();
    tests++; if ({t_timeout_err, t_busy, t_grant} !== 4'b0_1_01) begin
      fails++; $display("FAIL to_before_limit: got %b want 0101", {t_timeout_err, t_busy, t_grant}); end
    tick();
    tests++; if ({t_timeout_err, t_busy, t_grant, t_res_valid} !== 5'b1_0_00_0) begin
      fails++; $display("FAIL to_abort: got %b want 10000", {t_timeout_err, t_busy, t_grant, t_res_valid}); end
    t_req_valid = 2'b11; t_req_last = 2'b11;
    tick();
    t_req_valid = '0; t_req_last = '0;
    tests++; if (t_grant !== 2'b10) begin fails++; $display("FAIL to_rr_advance: got %b want 10", t_grant); end
    tick(); tick(); tick();
    t_core_ready = 1;
    tick();
    t_core_ready = 0;
    tests++; if ({t_res_valid, t_res_id, t_timeout_err} !== 3'b1_1_1) begin
      fails++; $display("FAIL to_recover: got %b want 111", {t_res_valid, t_res_id, t_timeout_err}); end
    t_res_ready = 1;
    tick();
    t_res_ready = 0;
    tests++; if ({t_timeout_err, t_busy} !== 2'b10) begin
      fails++; $display("FAIL to_sticky: got %b want 10", {t_timeout_err, t_busy}); end
  endtask

  // asynchronous reset during WAIT
  task automatic test_reset_mid();
    int bad;
    do_reset();
    req_valid = 2'b01; req_last = 2'b01;
    tick(); tick();
    core_ready = 1; tick(); core_ready = 0;
    res_ready = 1; tick(); res_ready = 0;   // rr_ptr now 1
    req_valid = 2'b10; req_last = 2'b10;
    tick(); tick(); tick();                  // req 1 in WAIT
    #2 ARESETn = 0;
    #1;
    tests++; if ({grant, blk_ack, core_valid, core_last, res_valid, res_id, busy, timeout_err} !== 10'b0) begin
      fails++; $display("FAIL async_reset: got %b want 0", {grant, blk_ack, core_valid, core_last, res_valid, res_id, busy, timeout_err}); end
    req_valid = '0; req_last = '0;
    tick();
    ARESETn = 1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin tick(); if ({blk_ack, res_valid, core_valid} !== 4'b0) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL reset_release_pulse: got %0d bad cycles want 0", bad); end
    req_valid = 2'b11; req_last = 2'b11;
    tick();
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL reset_rr_ptr: got %b want 01", grant); end
    req_valid = '0; req_last = '0;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_round_robin();
    test_multiblock();
    test_result_hold();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
